// File: rtl/game_master_fsm_multi_target_if.sv
// Signal bundle between the game-master FSM and the sprite engines and game top.
// master = game-master side (drives sprite strobes); slave = environment side.
interface game_master_fsm_multi_target_if #(
  parameter int N_TARGETS = 3,
  parameter int N_LIVES   = 3,
  parameter int WIN_SCORE = 3
);
  localparam int SCORE_W = $clog2(WIN_SCORE + 1);
  localparam int LIVES_W = $clog2(N_LIVES + 1);

  logic                 launch_key;
  logic                 collision;
  logic                 collision_bullet;
  logic [N_TARGETS-1:0] target_within_screen;
  logic                 bullet_within_screen;
  logic                 end_of_game_timer_running;

  logic [N_TARGETS-1:0] target_write_xy;
  logic [N_TARGETS-1:0] target_write_dxy;
  logic [N_TARGETS-1:0] target_enable_update;
  logic                 bullet_write_xy;
  logic                 bullet_write_dxy;
  logic                 spaceship_write_xy;
  logic                 spaceship_write_dxy;
  logic                 bullet_enable_update;
  logic                 spaceship_enable_update;
  logic [N_LIVES-1:0]   heart_visible;
  logic                 end_of_game_timer_start;
  logic                 game_won;
  logic                 game_over;
  logic [SCORE_W-1:0]   score;
  logic [LIVES_W-1:0]   n_lives;

  modport master (
    input  launch_key, collision, collision_bullet, target_within_screen,
           bullet_within_screen, end_of_game_timer_running,
    output target_write_xy, target_write_dxy, target_enable_update,
           bullet_write_xy, bullet_write_dxy, spaceship_write_xy, spaceship_write_dxy,
           bullet_enable_update, spaceship_enable_update, heart_visible,
           end_of_game_timer_start, game_won, game_over, score, n_lives
  );

  modport slave (
    output launch_key, collision, collision_bullet, target_within_screen,
           bullet_within_screen, end_of_game_timer_running,
    input  target_write_xy, target_write_dxy, target_enable_update,
           bullet_write_xy, bullet_write_dxy, spaceship_write_xy, spaceship_write_dxy,
           bullet_enable_update, spaceship_enable_update, heart_visible,
           end_of_game_timer_start, game_won, game_over, score, n_lives
  );
endinterface

// File: rtl/game_master_fsm_multi_target.sv
// Game-master FSM: N targets, life/score tracking, win/loss; every output is registered.
// Define GAME_TIME_LIMIT_EN to end the game when the external game timer stops running.
module game_master_fsm_multi_target #(
  parameter int N_TARGETS       = 3,
  parameter int N_LIVES         = 3,
  parameter int WIN_SCORE       = 3,
  parameter int END_HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  game_master_fsm_multi_target_if.master gm
);
  localparam int SCORE_W = $clog2(WIN_SCORE + 1);
  localparam int LIVES_W = $clog2(N_LIVES + 1);
  localparam int HOLD_W  = (END_HOLD_CYCLES > 2) ? $clog2(END_HOLD_CYCLES) : 1;

  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(N_LIVES);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(END_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    START_GAME,
    START_ROUND,
    AIM,
    SHOOT,
    MINUS_LIFE,
    PLUS_SCORE,
    END_ROUND,
    END_GAME
  } state_t;

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [LIVES_W-1:0]   n_lives_q, n_lives_d;
  logic                 game_won_q, game_won_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [N_LIVES-1:0]   heart_visible_q, heart_visible_d;
  logic [N_TARGETS-1:0] target_write_xy_q, target_write_xy_d;
  logic [N_TARGETS-1:0] target_write_dxy_q, target_write_dxy_d;
  logic [N_TARGETS-1:0] target_enable_update_q, target_enable_update_d;
  logic                 bullet_write_xy_q, bullet_write_xy_d;
  logic                 bullet_write_dxy_q, bullet_write_dxy_d;
  logic                 spaceship_write_xy_q, spaceship_write_xy_d;
  logic                 spaceship_write_dxy_q, spaceship_write_dxy_d;
  logic                 bullet_enable_update_q, bullet_enable_update_d;
  logic                 spaceship_enable_update_q, spaceship_enable_update_d;
  logic                 end_of_game_timer_start_q, end_of_game_timer_start_d;
  logic                 game_over_q, game_over_d;

  logic any_target_off;
  logic time_up;
  logic timer_start_en;

  assign any_target_off = ~(&gm.target_within_screen);

`ifdef GAME_TIME_LIMIT_EN
  assign time_up        = ~gm.end_of_game_timer_running;
  assign timer_start_en = 1'b1;
`else
  logic unused_timer_running;
  assign unused_timer_running = gm.end_of_game_timer_running;
  assign time_up              = 1'b0;
  assign timer_start_en       = 1'b0;
`endif

  always_comb begin
    state_d                   = state_q;
    score_d                   = score_q;
    n_lives_d                 = n_lives_q;
    game_won_d                = game_won_q;
    hold_cnt_d                = hold_cnt_q;
    heart_visible_d           = '0;
    target_write_xy_d         = '0;
    target_write_dxy_d        = '0;
    target_enable_update_d    = '0;
    bullet_write_xy_d         = 1'b0;
    bullet_write_dxy_d        = 1'b0;
    spaceship_write_xy_d      = 1'b0;
    spaceship_write_dxy_d     = 1'b0;
    bullet_enable_update_d    = 1'b0;
    spaceship_enable_update_d = 1'b0;
    end_of_game_timer_start_d = 1'b0;
    game_over_d               = 1'b0;

    case (state_q)
      START_GAME: begin
        score_d                   = '0;
        n_lives_d                 = LIVES_INIT;
        game_won_d                = 1'b0;
        end_of_game_timer_start_d = timer_start_en;
        state_d                   = START_ROUND;
      end
      START_ROUND: begin
        target_write_xy_d    = '1;
        target_write_dxy_d   = '1;
        spaceship_write_xy_d = 1'b1;
        bullet_write_xy_d    = 1'b1;
        state_d              = AIM;
      end
      AIM: begin
        target_enable_update_d = '1;
        if (gm.collision) begin
          state_d = MINUS_LIFE;
        end else if (gm.launch_key) begin
          // Velocity load is tied to the AIM->SHOOT transition so it fires once per shot.
          bullet_write_dxy_d    = 1'b1;
          spaceship_write_dxy_d = 1'b1;
          state_d               = SHOOT;
        end else if (any_target_off) begin
          state_d = END_ROUND;
        end else if (time_up) begin
          game_won_d = 1'b0;
          state_d    = END_GAME;
        end
      end
      SHOOT: begin
        target_enable_update_d    = '1;
        bullet_enable_update_d    = 1'b1;
        spaceship_enable_update_d = 1'b1;
        // Collision outranks a bullet hit, so a simultaneous pair costs a life and scores nothing.
        if (gm.collision) begin
          state_d = MINUS_LIFE;
        end else if (gm.collision_bullet) begin
          state_d = PLUS_SCORE;
        end else if (any_target_off || !gm.bullet_within_screen) begin
          state_d = END_ROUND;
        end else if (time_up) begin
          game_won_d = 1'b0;
          state_d    = END_GAME;
        end
      end
      MINUS_LIFE: begin
        if (n_lives_q != '0) n_lives_d = n_lives_q - LIVES_W'(1);
        state_d = END_ROUND;
      end
      PLUS_SCORE: begin
        if (score_q != WIN_VAL) score_d = score_q + SCORE_W'(1);
        state_d = END_ROUND;
      end
      END_ROUND: begin
        if (score_q == WIN_VAL) begin
          game_won_d = 1'b1;
          state_d    = END_GAME;
        end else if (n_lives_q == '0) begin
          game_won_d = 1'b0;
          state_d    = END_GAME;
        end else begin
          state_d = START_ROUND;
        end
      end
      END_GAME: begin
        game_over_d = 1'b1;
        if (hold_cnt_q == '0) state_d = START_GAME;
        else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end
      default: state_d = START_GAME;
    endcase

    if (state_d == END_GAME && state_q != END_GAME) hold_cnt_d = HOLD_LOAD;

    for (int i = 0; i < N_LIVES; i++) heart_visible_d[i] = (n_lives_d > LIVES_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                   <= START_GAME;
      score_q                   <= '0;
      n_lives_q                 <= LIVES_INIT;
      game_won_q                <= 1'b0;
      hold_cnt_q                <= '0;
      heart_visible_q           <= '1;
      target_write_xy_q         <= '0;
      target_write_dxy_q        <= '0;
      target_enable_update_q    <= '0;
      bullet_write_xy_q         <= 1'b0;
      bullet_write_dxy_q        <= 1'b0;
      spaceship_write_xy_q      <= 1'b0;
      spaceship_write_dxy_q     <= 1'b0;
      bullet_enable_update_q    <= 1'b0;
      spaceship_enable_update_q <= 1'b0;
      end_of_game_timer_start_q <= 1'b0;
      game_over_q               <= 1'b0;
    end else begin
      state_q                   <= state_d;
      score_q                   <= score_d;
      n_lives_q                 <= n_lives_d;
      game_won_q                <= game_won_d;
      hold_cnt_q                <= hold_cnt_d;
      heart_visible_q           <= heart_visible_d;
      target_write_xy_q         <= target_write_xy_d;
      target_write_dxy_q        <= target_write_dxy_d;
      target_enable_update_q    <= target_enable_update_d;
      bullet_write_xy_q         <= bullet_write_xy_d;
      bullet_write_dxy_q        <= bullet_write_dxy_d;
      spaceship_write_xy_q      <= spaceship_write_xy_d;
      spaceship_write_dxy_q     <= spaceship_write_dxy_d;
      bullet_enable_update_q    <= bullet_enable_update_d;
      spaceship_enable_update_q <= spaceship_enable_update_d;
      end_of_game_timer_start_q <= end_of_game_timer_start_d;
      game_over_q               <= game_over_d;
    end
  end

  assign gm.target_write_xy         = target_write_xy_q;
  assign gm.target_write_dxy        = target_write_dxy_q;
  assign gm.target_enable_update    = target_enable_update_q;
  assign gm.bullet_write_xy         = bullet_write_xy_q;
  assign gm.bullet_write_dxy        = bullet_write_dxy_q;
  assign gm.spaceship_write_xy      = spaceship_write_xy_q;
  assign gm.spaceship_write_dxy     = spaceship_write_dxy_q;
  assign gm.bullet_enable_update    = bullet_enable_update_q;
  assign gm.spaceship_enable_update = spaceship_enable_update_q;
  assign gm.heart_visible           = heart_visible_q;
  assign gm.end_of_game_timer_start = end_of_game_timer_start_q;
  assign gm.game_won                = game_won_q;
  assign gm.game_over               = game_over_q;
  assign gm.score                   = score_q;
  assign gm.n_lives                 = n_lives_q;
endmodule

// File: tb/tb_game_master_fsm_multi_target.sv
// Directed bench for game_master_fsm_multi_target (3 targets, 3 lives, win at 3, 16-cycle hold).
module tb_game_master_fsm_multi_target;
`ifdef GAME_TIME_LIMIT_EN
  localparam bit TL_EN = 1'b1;
`else
  localparam bit TL_EN = 1'b0;
`endif

  localparam int K_IDLE  = 0;
  localparam int K_TS    = 1;
  localparam int K_START = 2;
  localparam int K_AIM   = 3;
  localparam int K_FIRE  = 4;
  localparam int K_SHOOT = 5;
  localparam int K_OVER  = 6;

  typedef struct packed {
    logic       ts;
    logic [2:0] twxy;
    logic [2:0] twdxy;
    logic [2:0] ten;
    logic       bwxy;
    logic       bwdxy;
    logic       ben;
    logic       swxy;
    logic       swdxy;
    logic       sen;
    logic       go;
    logic       gw;
    logic [1:0] sc;
    logic [1:0] nl;
    logic [2:0] hv;
  } obs_t;

  typedef struct {
    logic       launch;
    logic       coll;
    logic       collb;
    logic [2:0] tws;
    logic       bws;
    int         kind;
    int         sc;
    int         nl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  game_master_fsm_multi_target_if #(.N_TARGETS(3), .N_LIVES(3), .WIN_SCORE(3)) bus ();

  game_master_fsm_multi_target #(
    .N_TARGETS(3), .N_LIVES(3), .WIN_SCORE(3), .END_HOLD_CYCLES(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .gm  (bus)
  );

  function automatic obs_t mk_obs(input int kind, input int sc, input int nl, input bit gw);
    obs_t o;
    o = '0;
    o.ts = (kind == K_TS) && TL_EN;
    case (kind)
      K_START: begin o.twxy = 3'b111; o.twdxy = 3'b111; o.bwxy = 1'b1; o.swxy = 1'b1; end
      K_AIM:   o.ten = 3'b111;
      K_FIRE:  begin o.ten = 3'b111; o.bwdxy = 1'b1; o.swdxy = 1'b1; end
      K_SHOOT: begin o.ten = 3'b111; o.ben = 1'b1; o.sen = 1'b1; end
      K_OVER:  o.go = 1'b1;
      default: ;
    endcase
    o.gw = gw;
    o.sc = 2'(sc);
    o.nl = 2'(nl);
    for (int i = 0; i < 3; i++) o.hv[i] = (nl > i);
    return o;
  endfunction

  function automatic obs_t get_obs();
    obs_t o;
    o.ts = bus.end_of_game_timer_start;
    o.twxy = bus.target_write_xy;
    o.twdxy = bus.target_write_dxy;
    o.ten = bus.target_enable_update;
    o.bwxy = bus.bullet_write_xy;
    o.bwdxy = bus.bullet_write_dxy;
    o.ben = bus.bullet_enable_update;
    o.swxy = bus.spaceship_write_xy;
    o.swdxy = bus.spaceship_write_dxy;
    o.sen = bus.spaceship_enable_update;
    o.go = bus.game_over;
    o.gw = bus.game_won;
    o.sc = bus.score;
    o.nl = bus.n_lives;
    o.hv = bus.heart_visible;
    return o;
  endfunction

  task automatic chk_obs(input string name, input obs_t exp);
    obs_t act;
    act = get_obs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.launch_key = 1'b0;
    bus.collision = 1'b0;
    bus.collision_bullet = 1'b0;
    bus.target_within_screen = 3'b111;
    bus.bullet_within_screen = 1'b1;
  endtask

  // Enters in AIM; fires, scores, and returns after END_ROUND has been evaluated.
  task automatic hit_round(input int exp_sc);
    bus.launch_key = 1'b1;
    tick();
    bus.launch_key = 1'b0;
    bus.collision_bullet = 1'b1;
    tick();
    bus.collision_bullet = 1'b0;
    tick();
    chk_int($sformatf("score_after_hit%0d", exp_sc), int'(bus.score), exp_sc);
    tick();
  endtask

  task automatic wait_game_over_end(output int n_high);
    n_high = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.game_over) break;
      n_high++;
      tick();
    end
  endtask

  vec_t tbl[30];

  initial begin
    int n_high;

    tbl[0]  = '{0, 0, 0, 3'b111, 1, K_TS,    0, 3};
    tbl[1]  = '{0, 0, 0, 3'b111, 1, K_START, 0, 3};
    tbl[2]  = '{0, 0, 0, 3'b111, 1, K_AIM,   0, 3};
    tbl[3]  = '{1, 0, 0, 3'b111, 1, K_FIRE,  0, 3};
    tbl[4]  = '{0, 0, 0, 3'b111, 1, K_SHOOT, 0, 3};
    tbl[5]  = '{0, 0, 0, 3'b111, 1, K_SHOOT, 0, 3};
    tbl[6]  = '{0, 0, 1, 3'b111, 1, K_SHOOT, 0, 3};
    tbl[7]  = '{0, 0, 0, 3'b111, 1, K_IDLE,  1, 3};
    tbl[8]  = '{0, 0, 0, 3'b111, 1, K_IDLE,  1, 3};
    tbl[9]  = '{0, 0, 0, 3'b111, 1, K_START, 1, 3};
    tbl[10] = '{0, 0, 0, 3'b101, 1, K_AIM,   1, 3};
    tbl[11] = '{0, 0, 0, 3'b111, 1, K_IDLE,  1, 3};
    tbl[12] = '{0, 0, 0, 3'b111, 1, K_START, 1, 3};
    tbl[13] = '{0, 1, 0, 3'b111, 1, K_AIM,   1, 3};
    tbl[14] = '{0, 0, 0, 3'b111, 1, K_IDLE,  1, 2};
    tbl[15] = '{0, 0, 0, 3'b111, 1, K_IDLE,  1, 2};
    tbl[16] = '{0, 0, 0, 3'b111, 1, K_START, 1, 2};
    tbl[17] = '{1, 0, 0, 3'b111, 1, K_FIRE,  1, 2};
    tbl[18] = '{0, 1, 1, 3'b111, 1, K_SHOOT, 1, 2};
    tbl[19] = '{0, 0, 0, 3'b111, 1, K_IDLE,  1, 1};
    tbl[20] = '{0, 0, 0, 3'b111, 1, K_IDLE,  1, 1};
    tbl[21] = '{0, 0, 0, 3'b111, 1, K_START, 1, 1};
    tbl[22] = '{1, 0, 0, 3'b111, 0, K_FIRE,  1, 1};
    tbl[23] = '{0, 0, 0, 3'b111, 0, K_SHOOT, 1, 1};
    tbl[24] = '{0, 0, 0, 3'b111, 1, K_IDLE,  1, 1};
    tbl[25] = '{0, 0, 0, 3'b111, 1, K_START, 1, 1};
    tbl[26] = '{0, 1, 0, 3'b111, 1, K_AIM,   1, 1};
    tbl[27] = '{0, 0, 0, 3'b111, 1, K_IDLE,  1, 0};
    tbl[28] = '{0, 0, 0, 3'b111, 1, K_IDLE,  1, 0};
    tbl[29] = '{0, 0, 0, 3'b111, 1, K_OVER,  1, 0};

    idle_inputs();
    bus.end_of_game_timer_running = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk_obs("reset", mk_obs(K_IDLE, 0, 3, 1'b0));
    rst = 1'b0;

    // Full first game: score once, then lose all three lives.
    for (int i = 0; i < 30; i++) begin
      bus.launch_key = tbl[i].launch;
      bus.collision = tbl[i].coll;
      bus.collision_bullet = tbl[i].collb;
      bus.target_within_screen = tbl[i].tws;
      bus.bullet_within_screen = tbl[i].bws;
      tick();
      chk_obs($sformatf("vec%0d", i), mk_obs(tbl[i].kind, tbl[i].sc, tbl[i].nl, 1'b0));
    end
    idle_inputs();

    wait_game_over_end(n_high);
    chk_int("lost_hold_cycles", n_high, 16);
    chk_obs("restart_after_loss", mk_obs(K_TS, 0, 3, 1'b0));

    // Winning game: three scoring rounds.
    tick();
    chk_obs("win_round_start", mk_obs(K_START, 0, 3, 1'b0));
    hit_round(1);
    tick();
    hit_round(2);
    tick();
    hit_round(3);
    chk_int("won_flag", int'(bus.game_won), 1);
    tick();
    chk_int("won_game_over", int'(bus.game_over), 1);
    wait_game_over_end(n_high);
    chk_int("won_hold_cycles", n_high, 16);
    chk_obs("restart_after_win", mk_obs(K_TS, 0, 3, 1'b0));

    // Reset while in SHOOT with score 2.
    tick();
    hit_round(1);
    tick();
    hit_round(2);
    tick();
    bus.launch_key = 1'b1;
    tick();
    bus.launch_key = 1'b0;
    tick();
    chk_obs("pre_reset_shoot", mk_obs(K_SHOOT, 2, 3, 1'b0));
    rst = 1'b1;
    tick();
    chk_obs("reset_mid_shoot", mk_obs(K_IDLE, 0, 3, 1'b0));
    rst = 1'b0;
    tick();
    chk_obs("start_after_reset", mk_obs(K_TS, 0, 3, 1'b0));

    // Game timer drops while aiming.
    tick();
    tick();
    chk_obs("aim_before_timeout", mk_obs(K_AIM, 0, 3, 1'b0));
    bus.end_of_game_timer_running = 1'b0;
    tick();
    tick();
    chk_obs("timer_expired", mk_obs(TL_EN ? K_OVER : K_AIM, 0, 3, 1'b0));
    bus.end_of_game_timer_running = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
